// File: rtl/vram_arbiter_pkg.sv
// Shared types for the VRAM arbiter: FSM states, grant sources and access kinds,
// plus the grant priority helper.
package vram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    VDP_RD = 2'd1,
    CPU_RD = 2'd2,
    CPU_WR = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_VDP  = 2'd1,
    SRC_CPU  = 2'd2
  } src_t;

  localparam logic ACC_READ  = 1'b0;
  localparam logic ACC_WRITE = 1'b1;

  // VDP wins unless the CPU has been starved long enough to be forced through.
  function automatic src_t pick_source(input logic vdp_req, input logic cpu_pending,
                                       input logic cpu_forced);
    src_t src;
    if (cpu_pending && cpu_forced) begin
      src = SRC_CPU;
    end else if (vdp_req) begin
      src = SRC_VDP;
    end else if (cpu_pending) begin
      src = SRC_CPU;
    end else begin
      src = SRC_NONE;
    end
    return src;
  endfunction

endpackage

// File: rtl/vram_req_buffer.sv
// One-entry holding register for a CPU access (direction, address, write data).
module vram_req_buffer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              in_we,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              full,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata
);

  // Capture on load into an empty slot; clear releases the slot.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full  <= 1'b0;
      we    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
    end else if (clear) begin
      full <= 1'b0;
    end else if (load && !full) begin
      full  <= 1'b1;
      we    <= in_we;
      addr  <= in_addr;
      wdata <= in_wdata;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter between VDP fetches and CPU accesses.
// Optional CPU starvation guard: define VRAM_ARB_STARVE_GUARD_EN.
module vram_arbiter
  import vram_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int MAX_VDP_RUN = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vdp_req,
  input  logic [ADDR_W-1:0] vdp_addr,
  output logic              vdp_valid,
  output logic [DATA_W-1:0] vdp_data,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_busy,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_overflow,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t            state;
  src_t              src;
  logic              buf_full;
  logic              buf_we;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_wdata;
  logic              cpu_pending;
  logic              cpu_forced;

  vram_req_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_req_buffer (
    .clk      (clk),
    .reset    (reset),
    .load     (cpu_req),
    .clear    (cpu_ack),
    .in_we    (cpu_we),
    .in_addr  (cpu_addr),
    .in_wdata (cpu_wdata),
    .full     (buf_full),
    .we       (buf_we),
    .addr     (buf_addr),
    .wdata    (buf_wdata)
  );

  assign cpu_busy = buf_full;
  // During the ack cycle the entry is already served but not yet released.
  assign cpu_pending = buf_full && !cpu_ack;

`ifdef VRAM_ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(MAX_VDP_RUN + 1);
  logic [CNT_W-1:0] vdp_run;

  assign cpu_forced = (vdp_run >= CNT_W'(MAX_VDP_RUN));

  // Counts VDP grants that overtook a waiting CPU access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vdp_run <= '0;
    end else if (!buf_full || src == SRC_CPU) begin
      vdp_run <= '0;
    end else if (src == SRC_VDP && !cpu_forced) begin
      vdp_run <= vdp_run + CNT_W'(1);
    end
  end
`else
  localparam int unused_max_vdp_run = MAX_VDP_RUN;
  assign cpu_forced = 1'b0;
`endif

  // Grant decision, only ever made in IDLE and never while in reset.
  always_comb begin
    src = SRC_NONE;
    if (!reset && state == IDLE) begin
      src = pick_source(vdp_req, cpu_pending, cpu_forced);
    end else begin
      src = SRC_NONE;
    end
  end

  // RAM port driven straight from the granted source in the grant cycle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = ACC_READ;
    mem_addr  = '0;
    mem_wdata = '0;
    case (src)
      SRC_VDP: begin
        mem_en   = 1'b1;
        mem_we   = ACC_READ;
        mem_addr = vdp_addr;
      end
      SRC_CPU: begin
        mem_en    = 1'b1;
        mem_we    = (buf_we == ACC_WRITE);
        mem_addr  = buf_addr;
        mem_wdata = buf_wdata;
      end
      default: begin
        mem_en = 1'b0;
      end
    endcase
  end

  // Access sequencer with registered completion strobes and data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      vdp_valid    <= 1'b0;
      vdp_data     <= '0;
      cpu_ack      <= 1'b0;
      cpu_rdata    <= '0;
      cpu_overflow <= 1'b0;
    end else begin
      vdp_valid <= 1'b0;
      cpu_ack   <= 1'b0;
      if (cpu_req && buf_full) begin
        cpu_overflow <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (src == SRC_VDP) begin
            state <= VDP_RD;
          end else if (src == SRC_CPU) begin
            if (buf_we == ACC_WRITE) begin
              state   <= CPU_WR;
              cpu_ack <= 1'b1;
            end else begin
              state <= CPU_RD;
            end
          end else begin
            state <= IDLE;
          end
        end
        VDP_RD: begin
          vdp_data  <= mem_rdata;
          vdp_valid <= 1'b1;
          state     <= IDLE;
        end
        CPU_RD: begin
          cpu_rdata <= mem_rdata;
          cpu_ack   <= 1'b1;
          state     <= IDLE;
        end
        CPU_WR: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed, table-driven bench for vram_arbiter with a behavioural sync RAM.
module tb_vram_arbiter;
  localparam int AW = 15;
  localparam int DW = 8;

  logic          clk, reset;
  logic          vdp_req, vdp_valid;
  logic [AW-1:0] vdp_addr;
  logic [DW-1:0] vdp_data;
  logic          cpu_req, cpu_we, cpu_busy, cpu_ack, cpu_overflow;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_VDP_RUN(4)) dut (
    .clk(clk), .reset(reset),
    .vdp_req(vdp_req), .vdp_addr(vdp_addr), .vdp_valid(vdp_valid), .vdp_data(vdp_data),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_busy(cpu_busy), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .cpu_overflow(cpu_overflow),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Unwritten locations read back as addr[7:0] ^ 8'h5A.
  logic [DW-1:0] ram [0:32767];
  bit            ram_wr [0:32767];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        ram[mem_addr]    <= mem_wdata;
        ram_wr[mem_addr] <= 1'b1;
      end else begin
        mem_rdata <= ram_wr[mem_addr] ? ram[mem_addr] : (mem_addr[7:0] ^ 8'h5A);
      end
    end
  end

  function automatic logic [44:0] pack(input logic men, input logic mwe, input logic [AW-1:0] maddr,
                                       input logic [DW-1:0] mwd, input logic vval, input logic [DW-1:0] vdata,
                                       input logic cack, input logic cbusy, input logic [DW-1:0] crd,
                                       input logic ovf);
    logic [23:0] port;
    port = men ? {mwe, maddr, (mwe ? mwd : 8'h00)} : 24'h000000;
    return {men, port, vval, vdata, cack, cbusy, crd, ovf};
  endfunction

  typedef struct {
    logic          vreq;
    logic [AW-1:0] vaddr;
    logic          creq, cwe;
    logic [AW-1:0] caddr;
    logic [DW-1:0] cwd;
    logic [44:0]   exp;
  } row_t;

  function automatic row_t mk(input logic vreq, input logic [AW-1:0] vaddr, input logic creq,
                              input logic cwe, input logic [AW-1:0] caddr, input logic [DW-1:0] cwd,
                              input logic [44:0] exp);
    row_t r;
    r.vreq = vreq; r.vaddr = vaddr; r.creq = creq; r.cwe = cwe;
    r.caddr = caddr; r.cwd = cwd; r.exp = exp;
    return r;
  endfunction

  function automatic logic [44:0] observed();
    return pack(mem_en, mem_we, mem_addr, mem_wdata, vdp_valid, vdp_data,
                cpu_ack, cpu_busy, cpu_rdata, cpu_overflow);
  endfunction

  task automatic chk_vec(input string name, input logic [44:0] act, input logic [44:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  row_t rows [21];
  int   vdp_g, cpu_g, vdp_before;
  bit   ack_seen;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    //                 vreq  vaddr     creq  cwe   caddr     cwd       men   mwe   maddr     mwd     vval  vdata  cack  busy  crd    ovf
    rows[0]  = mk(1'b0, 15'h0000, 1'b1, 1'b1, 15'h0123, 8'hA5, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
    rows[1]  = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b1, 1'b1, 15'h0123, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
    rows[2]  = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0));
    rows[3]  = mk(1'b0, 15'h0000, 1'b1, 1'b0, 15'h0123, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
    rows[4]  = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b1, 1'b0, 15'h0123, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
    rows[5]  = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0));
    rows[6]  = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0));
    rows[7]  = mk(1'b0, 15'h0000, 1'b1, 1'b0, 15'h0200, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0));
    rows[8]  = mk(1'b1, 15'h0010, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b1, 1'b0, 15'h0010, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0));
    rows[9]  = mk(1'b1, 15'h0010, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0));
    rows[10] = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b1, 1'b0, 15'h0200, 8'h00, 1'b1, 8'h4A, 1'b0, 1'b1, 8'hA5, 1'b0));
    rows[11] = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h4A, 1'b0, 1'b1, 8'hA5, 1'b0));
    rows[12] = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h4A, 1'b1, 1'b1, 8'h5A, 1'b0));
    rows[13] = mk(1'b0, 15'h0000, 1'b1, 1'b1, 15'h0040, 8'h11, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h4A, 1'b0, 1'b0, 8'h5A, 1'b0));
    rows[14] = mk(1'b0, 15'h0000, 1'b1, 1'b1, 15'h0050, 8'h22, pack(1'b1, 1'b1, 15'h0040, 8'h11, 1'b0, 8'h4A, 1'b0, 1'b1, 8'h5A, 1'b0));
    rows[15] = mk(1'b0, 15'h0000, 1'b1, 1'b0, 15'h0050, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h4A, 1'b1, 1'b1, 8'h5A, 1'b1));
    rows[16] = mk(1'b0, 15'h0000, 1'b1, 1'b0, 15'h0040, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h4A, 1'b0, 1'b0, 8'h5A, 1'b1));
    rows[17] = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b1, 1'b0, 15'h0040, 8'h00, 1'b0, 8'h4A, 1'b0, 1'b1, 8'h5A, 1'b1));
    rows[18] = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h4A, 1'b0, 1'b1, 8'h5A, 1'b1));
    rows[19] = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h4A, 1'b1, 1'b1, 8'h11, 1'b1));
    rows[20] = mk(1'b0, 15'h0000, 1'b0, 1'b0, 15'h0000, 8'h00, pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b0, 8'h4A, 1'b0, 1'b0, 8'h11, 1'b1));

    reset = 1'b1; vdp_req = 1'b1; vdp_addr = 15'h0010;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 15'h0000; cpu_wdata = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_vec("reset_outputs", observed(), 45'd0);

    for (int i = 0; i < 21; i++) begin
      @(posedge clk); #1;
      reset     = 1'b0;
      vdp_req   = rows[i].vreq;  vdp_addr  = rows[i].vaddr;
      cpu_req   = rows[i].creq;  cpu_we    = rows[i].cwe;
      cpu_addr  = rows[i].caddr; cpu_wdata = rows[i].cwd;
      @(negedge clk);
      chk_vec($sformatf("row%0d", i), observed(), rows[i].exp);
    end

    // CPU read waits behind a continuously requesting VDP.
    vdp_g = 0; cpu_g = 0; vdp_before = 0; ack_seen = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0060;
    @(posedge clk); #1;
    cpu_req = 1'b0; vdp_req = 1'b1; vdp_addr = 15'h0010;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (mem_en) begin
        if (mem_addr == 15'h0060 && mem_we == 1'b0) begin
          cpu_g++;
        end else begin
          vdp_g++;
          if (cpu_g == 0) vdp_before++;
        end
      end
      if (cpu_ack) ack_seen = 1'b1;
      @(posedge clk); #1;
    end
    vdp_req = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (cpu_ack) ack_seen = 1'b1;
      if (!cpu_busy && ack_seen) break;
      @(posedge clk); #1;
    end
`ifdef VRAM_ARB_STARVE_GUARD_EN
    chk_int("starve_vdp_before_cpu", vdp_before, 4);
    chk_int("starve_cpu_grants", cpu_g, 1);
`else
    chk_int("starve_vdp_before_cpu", vdp_before, 10);
    chk_int("starve_cpu_grants", cpu_g, 0);
`endif
    chk_int("starve_total_grants", vdp_g + cpu_g, 10);
    chk_int("starve_ack_seen", int'(ack_seen), 1);
    chk_int("starve_rdata", int'(cpu_rdata), 8'h3A);
    chk_int("starve_busy_low", int'(cpu_busy), 0);

    // Reset hitting an in-flight VDP read.
    @(posedge clk); #1;
    vdp_req = 1'b1; vdp_addr = 15'h0077;
    @(negedge clk);
    chk_vec("rst_pre_grant", observed(),
            pack(1'b1, 1'b0, 15'h0077, 8'h00, 1'b0, 8'h4A, 1'b0, 1'b0, 8'h3A, 1'b1));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk_vec("rst_in_vdp_rd", observed(), 45'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk_vec("rst_hold", observed(), 45'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk_vec("rst_first_grant", observed(),
            pack(1'b1, 1'b0, 15'h0077, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0));
    @(posedge clk); #1;
    @(negedge clk);
    chk_vec("rst_vdp_rd", observed(), 45'd0);
    @(posedge clk); #1;
    vdp_req = 1'b0;
    @(negedge clk);
    chk_vec("rst_vdp_valid", observed(),
            pack(1'b0, 1'b0, 15'h0000, 8'h00, 1'b1, 8'h2D, 1'b0, 1'b0, 8'h00, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15: VRAM word address width.
REQ-002 SHALL have parameter DATA_W, default 8: VRAM data width.
REQ-003 SHALL have parameter MAX_VDP_RUN, default 4: maximum consecutive VDP grants while a CPU access waits (guard only).
REQ-004 SHALL have ports:
- clk  in  1  system (dot) clock; one clock, all logic on posedge.
- reset  in  1  reset is asynchronous and active-high.
- vdp_req  in  1  VDP fetch request; held high until vdp_valid.
- vdp_addr  in  ADDR_W  VDP fetch address; stable while vdp_req high.
- vdp_valid  out  1  one-cycle pulse, vdp_data valid.
- vdp_data  out  DATA_W  fetched data; held until next vdp_valid.
- cpu_req  in  1  one-cycle CPU access strobe.
- cpu_we  in  1  1 = write, 0 = read; sampled with cpu_req.
- cpu_addr  in  ADDR_W  CPU address; sampled with cpu_req.
- cpu_wdata  in  DATA_W  CPU write data; sampled with cpu_req.
- cpu_busy  out  1  CPU request buffer full.
- cpu_ack  out  1  one-cycle pulse, CPU access complete.
- cpu_rdata  out  DATA_W  CPU read data; valid with cpu_ack on reads, held otherwise.
- cpu_overflow  out  1  sticky: cpu_req arrived while cpu_busy.
- mem_en, mem_we  out  1  synchronous single-port RAM enable / write enable.
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_rdata  in  DATA_W (valid the cycle after mem_en read).

Function
REQ-005 SHALL implement FSM states IDLE, VDP_RD, CPU_RD, CPU_WR.
REQ-006 SHALL capture cpu_req (when cpu_busy=0) into a one-entry buffer; cpu_busy=1 from next cycle through the cpu_ack cycle inclusive.
REQ-007 SHALL ignore cpu_req while cpu_busy=1 and set cpu_overflow; cpu_overflow clears only on reset.
REQ-008 In IDLE, grant cycle T: vdp_req wins over a buffered CPU access, except as REQ-016; with neither, stay IDLE, mem_en=0.
REQ-009 Grant cycle SHALL drive mem_en=1, mem_addr/mem_we/mem_wdata combinationally from the granted source; mem_en=0 in all other cycles.
REQ-010 VDP grant: IDLE->VDP_RD; at end of T+1 capture mem_rdata; vdp_valid=1 and vdp_data updated in T+2; ->IDLE.
REQ-011 CPU read: IDLE->CPU_RD; cpu_ack=1 and cpu_rdata updated in T+2; buffer emptied; ->IDLE.
REQ-012 CPU write: IDLE->CPU_WR; cpu_ack=1 in T+1; buffer emptied; ->IDLE.
REQ-013 Throughput SHALL be at most one access per two cycles; no new grant outside IDLE.
REQ-014 vdp_req dropped before grant: no access, no vdp_valid.
REQ-015 cpu_req in the same cycle as cpu_ack SHALL be rejected (busy still 1) and flagged per REQ-007.

Configuration
REQ-016 With VRAM_ARB_STARVE_GUARD_EN defined: counter counts VDP grants made while the CPU buffer is full, clears on CPU grant or empty buffer; at MAX_VDP_RUN the next IDLE grant goes to CPU despite vdp_req. Without it: strict VDP priority, no counter.

Reset
REQ-017 reset SHALL force IDLE, empty buffer, clear guard counter, discard any in-flight read; all outputs 0 (vdp_data, cpu_rdata, cpu_overflow included) while reset high.
REQ-018 First grant SHALL be possible in the first cycle after reset deasserts.

Structure
REQ-019 Package vram_arbiter_pkg SHALL hold the FSM state typedef and source/access-type constants.
REQ-020 One sub-module vram_req_buffer SHALL hold the one-entry CPU request (we, addr, wdata, full).

Verification
REQ-021 CPU write 0xA5 to 0x0123, no VDP traffic -> mem_we=1, mem_addr=0x0123 in T; cpu_ack in T+1; cpu_busy low after.
REQ-022 CPU read 0x0123 after REQ-021 -> cpu_ack in T+2, cpu_rdata=0xA5.
REQ-023 vdp_req held with vdp_addr=0x0010, CPU read pending simultaneously -> VDP granted first, vdp_valid at T+2; CPU granted at T+2 (next IDLE).
REQ-024 Guard build, vdp_req held continuously, CPU read pending -> exactly 4 VDP grants, then one CPU grant; without macro -> CPU never granted.
REQ-025 Second cpu_req while busy -> ignored, cpu_overflow=1 until reset; first access completes unaffected.
REQ-026 reset asserted in VDP_RD -> no vdp_valid, all outputs 0; after release, held vdp_req granted the first cycle.
